rca_seq_ctrl: RTL and testbench

//  Multi-byte add/subtract sequencer. It shares one external 8-bit ripple-carry adder

---
 rtl/rca_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_rca_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// Multi-byte add/subtract sequencer sharing one external 8-bit ripple-carry adder,
// one byte per clock LSB first, with the inter-byte carry held in a register.
module rca_seq_ctrl #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES,
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
  output logic         busy,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_s,
  input  logic         add_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

  state_t          state;
  logic [IDXW-1:0] idx;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    res_reg;
  logic            sub_reg;
  logic            carry_reg;
  logic            carry_out_r;
  logic            overflow_r;
  logic            in_ready_r;
  logic            busy_r;
  logic            out_valid_r;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  function automatic logic sgn_ovf(input logic a7, input logic b7,
                                   input logic s7, input logic cout);
    sgn_ovf = (a7 ^ b7 ^ s7) ^ cout;
  endfunction

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[8*idx +: 8];
      add_b   = b_reg[8*idx +: 8];
      add_cin = (idx == '0) ? sub_reg : carry_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      res_reg     <= '0;
      sub_reg     <= 1'b0;
      carry_reg   <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= op_a;
            b_reg      <= op_b ^ {W{op_sub}};
            sub_reg    <= op_sub;
            idx        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          res_reg[8*idx +: 8] <= add_s;
          carry_reg           <= add_cout;
          idx                 <= idx + 1'b1;
          if (idx == LAST) begin
            carry_out_r <= add_cout;
            overflow_r  <= sgn_ovf(add_a[7], add_b[7], add_s[7], add_cout);
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign result    = res_reg;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl with a behavioural 8-bit adder and a result scoreboard.
module tb_rca_seq_ctrl;

  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_s;
  logic         add_cout;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_bx;
  logic         cur_sub;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  rca_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry_out(carry_out),
    .overflow(overflow), .busy(busy), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: W-bit a+b or a-b with carry and signed overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W-1:0] bx;
    logic [W:0]   s;
    exp_t         e;
    bx  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
    e.r = s[W-1:0];
    e.c = s[W];
    e.v = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int n;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(n), 64'd0);
    tick();
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    op_sub   = ~sub;
    cur_a    = a;
    cur_bx   = sub ? ~b : b;
    cur_sub  = sub;
    sb.push_back(model(a, b, sub));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_add_a0", 64'(add_a), 64'(cur_a[7:0]));
    chk("run_add_b0", 64'(add_b), 64'(cur_bx[7:0]));
    chk("run_add_cin0", 64'(add_cin), 64'(cur_sub));
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(NBYTES));
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_in_ready", 64'(in_ready), 64'd0);
  endtask

  task automatic check_result();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk("result", 64'(result), 64'(e.r));
      chk("carry_out", 64'(carry_out), 64'(e.c));
      chk("overflow", 64'(overflow), 64'(e.v));
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_out_valid", 64'(out_valid), 64'd0);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("idle_add_a", 64'({add_a, add_b, add_cin}), 64'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    start_op(a, b, sub);
    wait_done();
    check_result();
    release_out();
  endtask

  initial begin
    logic [W-1:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'({result, carry_out, overflow}), 64'd0);
    chk("rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1);
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, 1'($urandom_range(0, 1)));

    // Back-pressure in DONE with a competing request.
    start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    wait_done();
    held     = result;
    in_valid = 1'b1;
    op_a     = 32'h0000_0010;
    op_b     = 32'h0000_0020;
    op_sub   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_result", 64'(result), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    check_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_in_ready", 64'(in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_next_busy", 64'(busy), 64'd1);
    sb.push_back(model(32'h0000_0010, 32'h0000_0020, 1'b0));
    cur_a   = 32'h0000_0010;
    cur_bx  = 32'h0000_0020;
    cur_sub = 1'b0;
    wait_done();
    check_result();
    release_out();

    // Reset asserted at the edge where idx==2.
    start_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_result", 64'({result, carry_out, overflow}), 64'd0);
    chk("mid_rst_add", 64'({add_a, add_b, add_cin}), 64'd0);
    sb.delete();
    run_op(32'h0102_0304, 32'h00FF_00FF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
